// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit-side FIFO.
package uart_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEFAULT_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with registered flags, occupancy count and overflow pulse.
// Pointers carry one extra MSB so full and empty are distinguishable while the
// low bits wrap naturally modulo the depth.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                wr_dv,
    input  logic [BYTE_W-1:0]   wr_byte,
    input  logic                pop,
    output logic [BYTE_W-1:0]   head_byte,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [BYTE_W-1:0]   storage [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [DEPTH_LOG2:0] wr_ptr_next;
    logic [DEPTH_LOG2:0] rd_ptr_next;
    logic                wr_accept;
    logic                pop_accept;

    // Accept decisions use the registered flags, so a write while full is
    // dropped even if a pop happens on the same edge.
    always_comb begin
        wr_accept   = wr_dv && !full;
        pop_accept  = pop && !empty;
        wr_ptr_next = wr_ptr + {{DEPTH_LOG2{1'b0}}, wr_accept};
        rd_ptr_next = rd_ptr + {{DEPTH_LOG2{1'b0}}, pop_accept};
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            storage[wr_ptr[DEPTH_LOG2-1:0]] <= wr_byte;
        end
    end

    // Pointers plus flags/count registered from the post-edge pointer values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            count    <= wr_ptr_next - rd_ptr_next;
            empty    <= (wr_ptr_next == rd_ptr_next);
            full     <= (wr_ptr_next[DEPTH_LOG2] != rd_ptr_next[DEPTH_LOG2]) &&
                        (wr_ptr_next[DEPTH_LOG2-1:0] == rd_ptr_next[DEPTH_LOG2-1:0]);
            overflow <= wr_dv && full;
        end
    end

    assign head_byte = storage[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and launch sequencer in front of the UART transmitter.
// Buffers host writes and launches them one at a time, waiting for each
// frame to complete plus one gap cycle before the next launch.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                i_Clock,
    input  logic                i_Rst_L,
    input  logic                i_Wr_DV,
    input  logic [BYTE_W-1:0]   i_Wr_Byte,
    output logic                o_Full,
    output logic                o_Empty,
    output logic [DEPTH_LOG2:0] o_Count,
    output logic                o_Overflow,
    output logic                o_TX_DV,
    output logic [BYTE_W-1:0]   o_TX_Byte,
    input  logic                i_TX_Active,
    input  logic                i_TX_Done
);

    tx_state_t         state;
    tx_state_t         state_next;
    logic              pop;
    logic              fifo_empty;
    logic [BYTE_W-1:0] head_byte;
    logic              tx_dv_r;
    logic [BYTE_W-1:0] tx_byte_r;

    uart_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock     (i_Clock),
        .rst_n     (i_Rst_L),
        .wr_dv     (i_Wr_DV),
        .wr_byte   (i_Wr_Byte),
        .pop       (pop),
        .head_byte (head_byte),
        .full      (o_Full),
        .empty     (fifo_empty),
        .count     (o_Count),
        .overflow  (o_Overflow)
    );

    // Launch FSM state register; reset parks in IDLE, where the busy check
    // keeps a frame still in flight from being overlapped.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and pop decision; done pulses only matter in WAIT_DONE.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !i_TX_Active) begin
                    pop        = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_TX_Done) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered launch pulse (high exactly while in SEND) and held launch byte.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_dv_r   <= 1'b0;
            tx_byte_r <= '0;
        end else begin
            tx_dv_r <= (state_next == ST_SEND);
            if (pop) begin
                tx_byte_r <= head_byte;
            end
        end
    end

    assign o_TX_DV   = tx_dv_r;
    assign o_TX_Byte = tx_byte_r;
    assign o_Empty   = fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural transmitter model
// and a scoreboard of accepted bytes compared at each launch.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH_LOG2  = 4;
    localparam int DEPTH       = 16;
    localparam int FRAME       = 24;
    localparam int MIN_SPACING = FRAME + 3;
    localparam int NVEC        = 18;

    typedef struct {
        logic       dv;
        logic [7:0] data;
        int         exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ovf;
    } vec_t;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_dv = 1'b0;
    logic [7:0] wr_byte = 8'h00;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;

    logic       hold_busy = 1'b0;
    logic       stray_done = 1'b0;
    logic       model_active = 1'b0;
    logic       model_done = 1'b0;
    int         model_cnt = 0;
    logic [7:0] model_byte = 8'h00;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         launch_count = 0;
    int         ovf_count = 0;
    int         peak_count = 0;
    int         tb_occ = 0;
    int         cyc = 0;
    int         last_launch = -1;
    logic [7:0] exp_q[$];
    vec_t       vecs[NVEC];

    assign tx_active = model_active | hold_busy;
    assign tx_done   = model_done | stray_done;

    uart_tx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .i_Clock     (clock),
        .i_Rst_L     (rst_n),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (overflow),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .i_TX_Active (tx_active),
        .i_TX_Done   (tx_done)
    );

    // Free-running clock and cycle counter.
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Transmitter model with no reset: busy for FRAME cycles after a launch,
    // then a one-cycle done pulse as it returns to idle.
    always @(posedge clock) begin
        model_done <= 1'b0;
        if (model_active) begin
            if (model_cnt == FRAME - 1) begin
                model_active <= 1'b0;
                model_done   <= 1'b1;
            end else begin
                model_cnt <= model_cnt + 1;
            end
        end else if (tx_dv === 1'b1) begin
            model_active <= 1'b1;
            model_cnt    <= 0;
            model_byte   <= tx_byte;
        end
    end

    task automatic checkCond(input string name, input bit ok, input longint actual, input longint required);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint required);
        checkCond(name, actual == required, actual, required);
    endtask

    // Launch monitor: scoreboard compare, spacing and busy-overlap checks.
    always @(negedge clock) begin
        if (overflow === 1'b1) ovf_count++;
        if (int'(count) > peak_count) peak_count = int'(count);
        if (tx_dv === 1'b1) begin
            launch_count++;
            checkOutput("launch_while_busy", tx_active, 0);
            if (last_launch >= 0) begin
                checkCond("launch_spacing", (cyc - last_launch) >= MIN_SPACING,
                          cyc - last_launch, MIN_SPACING);
            end
            last_launch = cyc;
            if (exp_q.size() == 0) begin
                checkCond("spurious_launch", 1'b0, tx_byte, -1);
            end else begin
                checkOutput("launch_byte", tx_byte, exp_q.pop_front());
                if (tb_occ > 0) tb_occ--;
            end
        end
    end

    // Drive one cycle of write stimulus; accepted bytes enter the scoreboard.
    task automatic applyStimulus(input logic dv, input logic [7:0] data);
        wr_dv   = dv;
        wr_byte = data;
        if (dv && tb_occ < DEPTH) begin
            exp_q.push_back(data);
            tb_occ++;
        end
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic waitLaunches(input int target, input string name);
        int budget;
        budget = (target - launch_count) * (FRAME + 10) + 20;
        wr_dv = 1'b0;
        for (int i = 0; i < budget && launch_count < target; i++) begin
            @(negedge clock);
            #1;
        end
        checkCond(name, launch_count >= target, launch_count, target);
    endtask

    task automatic waitFrameEnd();
        wr_dv = 1'b0;
        for (int i = 0; i < 4 * FRAME && model_active; i++) begin
            @(negedge clock);
            #1;
        end
        checkOutput("frame_end_timeout", model_active, 0);
        idle(4);
    endtask

    initial begin
        repeat (90000) @(posedge clock);
        $display("[TB] FAIL watchdog: got no finish, required finish within 90000 cycles");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int ovf_base;
        int sent;
        int blen;
        int dv_seen;

        // Full/overflow vectors: transmitter held busy, 17 writes then one idle.
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].dv        = (i < 17);
            vecs[i].data      = 8'(8'h40 + i);
            vecs[i].exp_count = (i + 1 >= DEPTH) ? DEPTH : i + 1;
            vecs[i].exp_full  = (i + 1 >= DEPTH);
            vecs[i].exp_empty = 1'b0;
            vecs[i].exp_ovf   = (i == 16);
        end

        // Reset then idle.
        repeat (5) @(negedge clock);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_tx_dv", tx_dv, 0);
        checkOutput("rst_tx_byte", tx_byte, 0);
        #1;
        rst_n = 1'b1;
        idle(100);
        checkOutput("idle_no_launch", launch_count, 0);
        checkOutput("idle_empty", empty, 1);

        // Single byte: launch pulse in the third cycle counting the write cycle.
        applyStimulus(1'b1, 8'h3F);
        checkOutput("single_dv_early", tx_dv, 0);
        checkOutput("single_empty_after_write", empty, 0);
        checkOutput("single_count", count, 1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("single_dv_latency", tx_dv, 1);
        checkOutput("single_tx_byte", tx_byte, 8'h3F);
        applyStimulus(1'b0, 8'h00);
        checkOutput("single_dv_one_cycle", tx_dv, 0);
        waitFrameEnd();
        checkOutput("single_rx_byte", model_byte, 8'h3F);
        checkOutput("single_launches", launch_count, 1);

        // Burst of five while briefly busy, with a stray done pulse in IDLE.
        base = launch_count;
        hold_busy = 1'b1;
        stray_done = 1'b1;
        applyStimulus(1'b1, 8'h01);
        stray_done = 1'b0;
        for (int i = 2; i <= 5; i++) applyStimulus(1'b1, 8'(i));
        checkOutput("burst_count_peak", count, 5);
        hold_busy = 1'b0;
        waitLaunches(base + 5, "burst_launch_timeout");
        checkOutput("burst_empty_after_fifth", empty, 1);
        waitFrameEnd();
        checkOutput("burst_queue_drained", exp_q.size(), 0);

        // Full and overflow, table driven.
        base = launch_count;
        ovf_base = ovf_count;
        hold_busy = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].dv, vecs[i].data);
            checkOutput($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            checkOutput($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
            checkOutput($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
            checkOutput($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_ovf);
        end
        checkOutput("ovf_pulses_once", ovf_count - ovf_base, 1);
        hold_busy = 1'b0;
        waitLaunches(base + 16, "full_drain_timeout");
        waitFrameEnd();
        idle(2 * FRAME);
        checkOutput("full_drain_launches", launch_count - base, 16);
        checkOutput("full_drain_queue", exp_q.size(), 0);

        // Wrap-around: 40 random bytes in random bursts, never overfilled.
        base = launch_count;
        ovf_base = ovf_count;
        peak_count = 0;
        sent = 0;
        while (sent < 40) begin
            blen = $urandom_range(1, 6);
            for (int k = 0; k < blen && sent < 40; k++) begin
                if (tb_occ < DEPTH) begin
                    applyStimulus(1'b1, 8'($urandom));
                    sent++;
                end else begin
                    applyStimulus(1'b0, 8'h00);
                end
            end
            idle($urandom_range(0, 20));
        end
        waitLaunches(base + 40, "wrap_launch_timeout");
        waitFrameEnd();
        checkOutput("wrap_launches", launch_count - base, 40);
        checkOutput("wrap_no_overflow", ovf_count - ovf_base, 0);
        checkCond("wrap_peak_count", peak_count <= DEPTH && peak_count > 0, peak_count, DEPTH);
        checkOutput("wrap_empty", empty, 1);

        // Reset mid-frame: queued bytes are lost, no launch until the frame ends.
        base = launch_count;
        applyStimulus(1'b1, 8'h5A);
        waitLaunches(base + 1, "midframe_first_launch");
        idle(8);
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h22);
        wr_dv = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        tb_occ = 0;
        idle(3);
        rst_n = 1'b1;
        last_launch = -1;
        checkOutput("midframe_rst_empty", empty, 1);
        checkOutput("midframe_rst_count", count, 0);
        checkOutput("midframe_rst_tx_byte", tx_byte, 0);
        checkOutput("midframe_still_busy", model_active, 1);
        applyStimulus(1'b1, 8'hA5);
        wr_dv = 1'b0;
        dv_seen = 0;
        for (int i = 0; i < 4 * FRAME && model_active; i++) begin
            @(negedge clock);
            #1;
            if (tx_dv === 1'b1) dv_seen++;
        end
        checkOutput("midframe_no_dv_while_busy", dv_seen, 0);
        base = launch_count;
        waitLaunches(base + 1, "midframe_a5_launch");
        waitFrameEnd();
        checkOutput("midframe_rx_byte", model_byte, 8'hA5);
        idle(2 * FRAME);
        checkOutput("midframe_lost_bytes_absent", launch_count - base, 1);
        checkOutput("midframe_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and launch sequencer placed directly upstream of the UART transmitter. Accepts bytes from a host-side write strobe into a circular FIFO, then feeds them one at a time to the transmitter using its i_TX_DV / i_TX_Byte / o_TX_Active / o_TX_Done handshake. Lets producers burst bytes without waiting on each frame to finish serialising.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 = 16 entries; legal range 1..8.

Ports:
i_Clock  in  1  system clock; all state on rising edge.
i_Rst_L  in  1  reset; asynchronous assert, active-low; deassert synchronous to i_Clock.
i_Wr_DV  in  1  write strobe; one byte per cycle while high.
i_Wr_Byte  in  8  write data, sampled when i_Wr_DV=1.
o_Full  out  1  FIFO holds DEPTH bytes.
o_Empty  out  1  FIFO holds 0 bytes.
o_Count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
o_Overflow  out  1  one-cycle pulse: write dropped because FIFO full.
o_TX_DV  out  1  one-cycle launch pulse to transmitter.
o_TX_Byte  out  8  byte to transmit; valid with o_TX_DV, held stable until next launch.
i_TX_Active  in  1  transmitter busy serialising.
i_TX_Done  in  1  transmitter one-cycle end-of-frame pulse.

Behaviour:
- Reset values: o_Empty=1, o_Full=0, o_Count=0, o_Overflow=0, o_TX_DV=0, o_TX_Byte=8'h00; read/write pointers 0; FSM in IDLE.
- Pointers DEPTH_LOG2+1 bits wide; extra MSB distinguishes full vs empty; low bits wrap modulo DEPTH with no special case.
- Write: i_Wr_DV=1 and !o_Full -> store at wr_ptr, wr_ptr+1. i_Wr_DV=1 and o_Full -> byte discarded, o_Overflow=1 next cycle, pointers unchanged. Decided: a write is dropped when o_Full even if a pop happens in the same cycle.
- Flags/count registered; they reflect all writes/pops from the previous edge (one-cycle latency write -> o_Empty=0).
- Simultaneous write and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- FSM states:
  IDLE: if !o_Empty and !i_TX_Active -> pop head into o_TX_Byte, assert o_TX_DV next cycle, go SEND.
  SEND: o_TX_DV=1 for exactly this one cycle; go WAIT_DONE.
  WAIT_DONE: hold o_TX_DV=0; on i_TX_Done=1 go GAP.
  GAP: one idle cycle so the transmitter can return to idle; go IDLE.
- Minimum spacing between launches: frame time + 3 cycles. A byte written into an empty FIFO with transmitter idle reaches o_TX_DV 3 cycles after the i_Wr_DV edge (write, flag update, pop).
- i_TX_Done seen outside WAIT_DONE is ignored.
- Reset mid-frame: the transmitter itself has no reset and finishes its frame. After reset the FSM stays in IDLE until i_TX_Active=0, so no launch overlaps a frame in flight. FIFO contents are lost.
- No combinational path from any input to any output.

Decomposition:
- Shared package uart_pkg: FSM state encodings (2-bit), byte width constant 8, default DEPTH_LOG2.
- One sub-module: uart_byte_fifo. Holds storage array, pointers, count, flags and overflow, with a pop/ready interface. uart_tx_fifo holds the launch FSM and the output registers.

Test Plan:
- Reset then idle: i_Rst_L low 5 cycles -> o_Empty=1, o_Count=0, o_TX_DV never asserted over 100 cycles.
- Single byte: write 8'h3F, real transmitter at CLKS_PER_BIT=217 with a receiver on the line -> o_TX_DV pulses once, 3 cycles after the write; receiver outputs 8'h3F.
- Burst: write 8'h01..8'h05 on consecutive cycles -> o_Count peaks at 5. Five launches in order 01..05, each at least 2173 cycles apart; o_Empty=1 after fifth pop.
- Full/overflow with DEPTH_LOG2=4: transmitter held busy (i_TX_Active=1), write 17 bytes -> o_Full=1 after the 16th write, o_Overflow pulses once. After draining, 16 bytes are received and the 17th is absent.
- Wrap-around: 40 bytes pushed in random bursts, none dropped -> all 40 transmitted in order, pointers wrap twice, o_Count never exceeds 16.
- Reset mid-frame: assert i_Rst_L low during a frame -> o_TX_DV stays 0 until i_TX_Active falls. The next written byte 8'hA5 then launches cleanly and is received intact.
